// File: rtl/regfile16.sv
// 16 x WIDTH register bank: one synchronous write port, two combinational read ports, R15 reads zero.
// Optional write-through forwarding on both read ports when REGFILE_BYPASS_EN is defined.

module mux16_1 (
    input  logic [15:0] i_in,
    input  logic [3:0]  i_sel,
    output logic        o_out
);
    assign o_out = i_in[i_sel];
endmodule

module regfile16 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  logic [3:0]       WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [3:0]       ReadRegister1,
    input  logic [3:0]       ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2
);
    logic [WIDTH-1:0]       r_regs [15];
    logic [14:0]            w_we;
    logic [WIDTH-1:0][15:0] w_cols;
    logic [WIDTH-1:0]       w_rd1;
    logic [WIDTH-1:0]       w_rd2;

    // One-hot write decode; address 15 has no storage, so its enable is never built.
    genvar gi, gb;
    generate
        for (gi = 0; gi < 15; gi++) begin : g_dec
            assign w_we[gi] = RegWrite && (WriteRegister == 4'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 15; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 0; i < 15; i++)
                if (w_we[i]) r_regs[i] <= WriteData;
        end
    end

    // Per data bit: gather bit b of every register, input 15 tied low, then one mux per port.
    generate
        for (gb = 0; gb < WIDTH; gb++) begin : g_bit
            for (gi = 0; gi < 15; gi++) begin : g_col
                assign w_cols[gb][gi] = r_regs[gi][gb];
            end
            assign w_cols[gb][15] = 1'b0;

            mux16_1 u_mux1 (
                .i_in  (w_cols[gb]),
                .i_sel (ReadRegister1),
                .o_out (w_rd1[gb])
            );
            mux16_1 u_mux2 (
                .i_in  (w_cols[gb]),
                .i_sel (ReadRegister2),
                .o_out (w_rd2[gb])
            );
        end
    endgenerate

`ifdef REGFILE_BYPASS_EN
    logic w_wr_live;
    logic w_byp1;
    logic w_byp2;

    assign w_wr_live = RegWrite && reset && (WriteRegister != 4'hF);
    assign w_byp1    = w_wr_live && (ReadRegister1 == WriteRegister);
    assign w_byp2    = w_wr_live && (ReadRegister2 == WriteRegister);
    assign ReadData1 = w_byp1 ? WriteData : w_rd1;
    assign ReadData2 = w_byp2 ? WriteData : w_rd2;
`else
    assign ReadData1 = w_rd1;
    assign ReadData2 = w_rd2;
`endif

endmodule

// File: tb/tb_regfile16.sv
// Scoreboard bench for regfile16: stimulus pushes expected read data, a monitor pops and compares.
// Follows REGFILE_BYPASS_EN in its reference model so it checks either build.

module tb_regfile16;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         RegWrite;
    logic [3:0]   WriteRegister;
    logic [W-1:0] WriteData;
    logic [3:0]   ReadRegister1;
    logic [3:0]   ReadRegister2;
    logic [W-1:0] ReadData1;
    logic [W-1:0] ReadData2;

    regfile16 #(.WIDTH(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d1;
        logic [W-1:0] d2;
        logic [3:0]   a1;
        logic [3:0]   a2;
    } exp_t;

    exp_t         sb_q[$];
    logic         rd_vld = 1'b0;
    logic [W-1:0] model [16];
    int           n_vec = 0;
    int           n_bad = 0;

    function automatic logic [W-1:0] ref_rd(input logic [3:0] a);
        if (a == 4'hF) return '0;
`ifdef REGFILE_BYPASS_EN
        if (reset && RegWrite && WriteRegister != 4'hF && a == WriteRegister) return WriteData;
`endif
        return model[a];
    endfunction

    // One cycle: drive at negedge, enqueue expected reads, then apply the edge to the model.
    task automatic step(input logic rst, input logic we, input logic [3:0] wa,
                        input logic [W-1:0] wd, input logic [3:0] a1, input logic [3:0] a2,
                        input logic chk);
        exp_t e;
        @(negedge clk);
        reset = rst; RegWrite = we; WriteRegister = wa; WriteData = wd;
        ReadRegister1 = a1; ReadRegister2 = a2;
        rd_vld = chk;
        if (chk) begin
            e.d1 = ref_rd(a1); e.d2 = ref_rd(a2); e.a1 = a1; e.a2 = a2;
            sb_q.push_back(e);
        end
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 16; i++) model[i] = '0;
        end else if (we && wa != 4'hF) begin
            model[wa] = wd;
        end
    endtask

    task automatic rd(input logic [3:0] a1, input logic [3:0] a2);
        step(1'b1, 1'b0, 4'd0, '0, a1, a2, 1'b1);
    endtask

    // Monitor: read ports are combinational, so sample well after the drive edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rd_vld) begin
                if (sb_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL sb_underflow: read presented with empty scoreboard");
                end else begin
                    e = sb_q.pop_front();
                    n_vec += 2;
                    if (ReadData1 !== e.d1) begin
                        n_bad++;
                        $display("FAIL rd1[%0d]: got %h want %h", e.a1, ReadData1, e.d1);
                    end
                    if (ReadData2 !== e.d2) begin
                        n_bad++;
                        $display("FAIL rd2[%0d]: got %h want %h", e.a2, ReadData2, e.d2);
                    end
                end
            end
        end
    end

    initial begin
        logic [W-1:0] base;
        int           wait_cyc;
        for (int i = 0; i < 16; i++) model[i] = '0;
        reset = 1'b0; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
        ReadRegister1 = '0; ReadRegister2 = '0;

        // Reset held 2 cycles against a live write to R3; storage is unknown before the first edge.
        step(1'b0, 1'b1, 4'd3, {W{1'b1}}, 4'd3, 4'd3, 1'b0);
        step(1'b0, 1'b1, 4'd3, {W{1'b1}}, 4'd3, 4'd0, 1'b1);
        for (int a = 0; a < 16; a++) rd(4'(a), 4'(15 - a));

        // Walking write then cross sweep
        base = 64'h0123_4567_89AB_CDE0;
        for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 4'(i), base + W'(i), 4'(i), 4'(14 - i), 1'b1);
        for (int i = 0; i < 15; i++) rd(4'(i), 4'(14 - i));

        // Zero register ignores writes
        step(1'b1, 1'b1, 4'hF, 64'hDEAD_BEEF_DEAD_BEEF, 4'hF, 4'd0, 1'b1);
        for (int a = 0; a < 16; a++) rd(4'(a), 4'hF);

        // Write enable low holds state
        step(1'b1, 1'b1, 4'd5, 64'h5555, 4'd5, 4'd5, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 4'd5, 64'hAAAA, 4'd5, 4'd4, 1'b1);
        rd(4'd5, 4'd5);

        // Same-cycle read/write of R7, port 2 on R8
        step(1'b1, 1'b1, 4'd7, 64'h1, 4'd7, 4'd8, 1'b1);
        step(1'b1, 1'b1, 4'd7, 64'h2, 4'd7, 4'd8, 1'b1);
        rd(4'd7, 4'd8);

        // Reset wins over a simultaneous write
        step(1'b1, 1'b1, 4'd2, 64'h77, 4'd2, 4'd2, 1'b1);
        step(1'b0, 1'b1, 4'd2, 64'h99, 4'd2, 4'd7, 1'b1);
        rd(4'd2, 4'd7);

        // Randomized traffic with occasional reset
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 24) != 0), 1'($urandom), 4'($urandom),
                 {$urandom, $urandom}, 4'($urandom), 4'($urandom), 1'b1);
        end

        @(negedge clk);
        rd_vld = 1'b0;
        wait_cyc = 0;
        while (sb_q.size() != 0 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (sb_q.size() != 0) begin
            n_vec++; n_bad++;
            $display("FAIL sb_drain: %0d entries left, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
